vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 73 +++++++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, per-axis flag bundle and total-length helpers
// used by the timing generator and its axis counters.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_X_W      = 10;
  localparam int DEF_Y_W      = 10;

  typedef struct packed {
    logic sync;
    logic start;
  } axis_flags_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: position counter with wrap/restart, plus registered sync and
// start-of-axis flags decoded from the same next position as the counter.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int W      = DEF_X_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         restart,
  output logic [W-1:0] count,
  output logic         active_next,
  output logic         sync,
  output logic         start
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  generate
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
      $error("vga_axis_counter: active, porch and sync lengths must be >= 1");
    end
  endgenerate

  logic [W-1:0] count_q, count_d;
  axis_flags_t  flags_q, flags_d;

  // Flags decode count_d so that after the edge they describe count_q exactly.
  always_comb begin
    count_d       = count_q;
    flags_d.start = 1'b0;
    if (restart) begin
      count_d       = '0;
      flags_d.start = 1'b1;
    end else if (step) begin
      if (count_q == LAST) begin
        count_d       = '0;
        flags_d.start = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
    active_next  = (count_d < ACTIVE_END);
    flags_d.sync = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
  end

  // Reset parks on the last back-porch position, so sync is inactive there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q       <= LAST;
      flags_q.sync  <= ~POL;
      flags_q.start <= 1'b0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count = count_q;
  assign sync  = flags_q.sync;
  assign start = flags_q.start;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters chained by the
// line wrap, with registered visibility/blanking flags and event pulses.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           restart,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);

  generate
    if (X_W < 1 || X_W > 30 || Y_W < 1 || Y_W > 30 ||
        H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_width
      $error("vga_timing_gen: X_W/Y_W too narrow for H_TOTAL-1/V_TOTAL-1");
    end
  endgenerate

  logic h_wrap;
  logic h_active_d, v_active_d;
  logic display_on_q, display_on_d;
  logic vblank_q, vblank_d;

  // The vertical axis only steps on a genuine line wrap; restart handles itself.
  assign h_wrap = ce && !restart && (x == H_LAST);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (X_W)
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (ce),
    .restart     (restart),
    .count       (x),
    .active_next (h_active_d),
    .sync        (hsync),
    .start       (line_start)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (Y_W)
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (h_wrap),
    .restart     (restart),
    .count       (y),
    .active_next (v_active_d),
    .sync        (vsync),
    .start       (frame_start)
  );

  always_comb begin
    display_on_d = h_active_d && v_active_d;
    vblank_d     = !v_active_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_on_q <= 1'b0;
      vblank_q     <= 1'b1;
    end else begin
      display_on_q <= display_on_d;
      vblank_q     <= vblank_d;
    end
  end

  assign display_on = display_on_q;
  assign vblank     = vblank_q;

endmodule
